// File: rtl/packet_rx_pkg.sv
// Shared constants and state type for the temperature packet receive path.
package packet_pkg;

   localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
   localparam int         DATA_BYTES_DEF  = 4;
   localparam int         SYNC_STAGES_DEF = 2;

   typedef enum logic {
      HUNT,
      COLLECT
   } rx_state_t;

endpackage

// File: rtl/packet_rx_sync_edge.sv
// Multi-flop synchronizer with a registered rising-edge pulse.
// The pulse is asserted in exactly the cycle the synced value is first seen high.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk_50,
   input  logic reset_n,
   input  logic d_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              rise_q;

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         // Registered form of (synced & ~synced_prev): looks one stage earlier.
         rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/packet_rx.sv
// Serial front-end: oversamples ser_clk/ser_data, hunts for the header byte with a
// sliding window, then emits DATA_BYTES bytes per packet to the word buffer.
module packet_rx
   import packet_pkg::*;
#(
   parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF,
   parameter int         DATA_BYTES  = DATA_BYTES_DEF,
   parameter int         SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic       clk_50,
   input  logic       reset_n,
   input  logic       ser_clk,
   input  logic       ser_data,
   input  logic       ser_en,
   output logic [7:0] packet_out,
   output logic       write_en,
   output logic       header_flag,
   output logic       pkt_done,
   output logic       frame_err
);

   localparam int BCW = $clog2(DATA_BYTES + 1);

   logic [SYNC_STAGES-1:0] data_sync_q, en_sync_q;
   logic                   sclk_rise, data_s, en_s, en_prev_q;
   logic                   shift_en, en_fall;

   rx_state_t              state_q;
   // Only 7 bits are kept: the oldest bit falls off on the shift that would read it.
   logic [6:0]             shift_q;
   logic [7:0]             shift_d;
   logic [2:0]             bit_cnt_q;
   logic [BCW-1:0]         byte_cnt_q;
   logic [7:0]             packet_out_q;
   logic                   write_en_q, header_flag_q, pkt_done_q, frame_err_q;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk_50  (clk_50),
      .reset_n (reset_n),
      .d_i     (ser_clk),
      .rise_o  (sclk_rise)
   );

   // Data and enable chains match the clock chain depth so they line up with sclk_rise.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         data_sync_q <= '0;
         en_sync_q   <= '0;
         en_prev_q   <= 1'b0;
      end else begin
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ser_data};
         en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], ser_en};
         en_prev_q   <= en_s;
      end
   end

   assign data_s   = data_sync_q[SYNC_STAGES-1];
   assign en_s     = en_sync_q[SYNC_STAGES-1];
   assign shift_en = sclk_rise & en_s;
   assign en_fall  = en_prev_q & ~en_s;
   assign shift_d  = {shift_q, data_s};

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= HUNT;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         packet_out_q  <= '0;
         write_en_q    <= 1'b0;
         header_flag_q <= 1'b0;
         pkt_done_q    <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         write_en_q    <= 1'b0;
         header_flag_q <= 1'b0;
         pkt_done_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         case (state_q)
            HUNT: begin
               if (shift_en) begin
                  shift_q <= shift_d[6:0];
                  if (shift_d == HEADER_BYTE) begin
                     header_flag_q <= 1'b1;
                     state_q       <= COLLECT;
                     bit_cnt_q     <= '0;
                     byte_cnt_q    <= '0;
                  end
               end
            end
            COLLECT: begin
               // Abort outranks a byte completing in the same cycle.
               if (en_fall) begin
                  frame_err_q <= 1'b1;
                  state_q     <= HUNT;
                  shift_q     <= '0;
                  bit_cnt_q   <= '0;
                  byte_cnt_q  <= '0;
               end else if (shift_en) begin
                  shift_q   <= shift_d[6:0];
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     packet_out_q <= shift_d;
                     write_en_q   <= 1'b1;
                     byte_cnt_q   <= byte_cnt_q + BCW'(1);
                     if (byte_cnt_q == BCW'(DATA_BYTES - 1)) begin
                        // Clearing the window keeps data tails from faking a header.
                        pkt_done_q <= 1'b1;
                        state_q    <= HUNT;
                        shift_q    <= '0;
                        byte_cnt_q <= '0;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign packet_out  = packet_out_q;
   assign write_en    = write_en_q;
   assign header_flag = header_flag_q;
   assign pkt_done    = pkt_done_q;
   assign frame_err   = frame_err_q;

endmodule
